// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the flag/branch unit: condition codes, FSM states, flag bit positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package flag_branch_unit_pkg;

    // Condition codes carried in br_cond
    localparam logic [2:0] BR_NE = 3'd0;
    localparam logic [2:0] BR_EQ = 3'd1;
    localparam logic [2:0] BR_GT = 3'd2;
    localparam logic [2:0] BR_LT = 3'd3;
    localparam logic [2:0] BR_GE = 3'd4;
    localparam logic [2:0] BR_LE = 3'd5;
    localparam logic [2:0] BR_OV = 3'd6;
    localparam logic [2:0] BR_UN = 3'd7;

    // Bit positions inside the {V,Z,N} flag vector
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        FBU_IDLE  = 1'b0,
        FBU_FLUSH = 1'b1
    } fbuState_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] satInc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

endpackage

// File: rtl/flag_branch_unit_br_cond_eval.sv
// Branch condition evaluator: decides taken/not-taken from a condition code and {V,Z,N}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is valid whenever inputs are.
// Ports: cond (condition code), flags ({V,Z,N}), taken (condition holds).
module br_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic flagV;
    logic flagZ;
    logic flagN;

    assign flagV = flags[FLAG_V];
    assign flagZ = flags[FLAG_Z];
    assign flagN = flags[FLAG_N];

    always_comb begin
        taken = 1'b1;
        case (cond)
            BR_NE:   taken = !flagZ;
            BR_EQ:   taken = flagZ;
            BR_GT:   taken = !flagZ && !flagN;
            BR_LT:   taken = flagN;
            // GE written as "equal or greater" so it mirrors GT/EQ literally
            BR_GE:   taken = flagZ || (!flagZ && !flagN);
            BR_LE:   taken = flagN || flagZ;
            BR_OV:   taken = flagV;
            default: taken = 1'b1;    // BR_UN
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register + EX-stage conditional branch resolver with redirect and wrong-path flush sequencing.
// Latency: flag write -> flags_out 1 cycle; taken branch -> redirect/redirect_pc 1 cycle.
// Backpressure: stall freezes every register (redirect pulse stretches); no branch is evaluated while stalled.
// Ports: clk, rst_n (async active-low); stall; flag_we, v_in/z_in/n_in (ALU flags);
//        br_valid, br_cond, br_pc_plus1, br_offset (EX branch); flags_out, redirect, redirect_pc,
//        flush, busy, taken_cnt (results).
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flag_we,
    input  logic            v_in,
    input  logic            z_in,
    input  logic            n_in,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_pc_plus1,
    input  logic [8:0]      br_offset,
    output logic [2:0]      flags_out,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic            busy,
    output logic [15:0]     taken_cnt
);

    // Counter runs FLUSH_CYCLES-1 down to 0, one state-cycle per value
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    fbuState_t       stateQ, stateN;
    logic [2:0]      cntQ, cntN;
    logic [2:0]      flagsQ, flagsN;
    logic            redirectQ, redirectN;
    logic [PC_W-1:0] redirectPcQ, redirectPcN;
    logic [15:0]     takenCntQ, takenCntN;

    logic [2:0]      aluFlags;
    logic [2:0]      effFlags;
    logic            condTaken;
    logic [PC_W-1:0] targetPc;

    assign aluFlags = {v_in, z_in, n_in};

    // The flag writer in EX is older than the branch, so its result is forwarded
    assign effFlags = flag_we ? aluFlags : flagsQ;

    assign targetPc = br_pc_plus1 + {{(PC_W-9){br_offset[8]}}, br_offset};

    br_cond_eval uCondEval (
        .cond  (br_cond),
        .flags (effFlags),
        .taken (condTaken)
    );

    always_comb begin
        stateN      = stateQ;
        cntN        = cntQ;
        flagsN      = flagsQ;
        redirectN   = redirectQ;
        redirectPcN = redirectPcQ;
        takenCntN   = takenCntQ;

        if (!stall) begin
            case (stateQ)
                FBU_IDLE: begin
                    redirectN = 1'b0;
                    if (flag_we) begin
                        flagsN = aluFlags;
                    end
                    if (br_valid && condTaken) begin
                        redirectN   = 1'b1;
                        redirectPcN = targetPc;
                        takenCntN   = satInc16(takenCntQ);
                        cntN        = CNT_INIT;
                        stateN      = FBU_FLUSH;
                    end
                end
                FBU_FLUSH: begin
                    // Everything arriving in EX now is wrong-path: no flag writes, no branches
                    redirectN = 1'b0;
                    if (cntQ == 3'd0) begin
                        stateN = FBU_IDLE;
                    end else begin
                        cntN = cntQ - 3'd1;
                    end
                end
                default: begin
                    stateN    = FBU_IDLE;
                    redirectN = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ      <= FBU_IDLE;
            cntQ        <= 3'd0;
            flagsQ      <= 3'b000;
            redirectQ   <= 1'b0;
            redirectPcQ <= '0;
            takenCntQ   <= 16'd0;
        end else begin
            stateQ      <= stateN;
            cntQ        <= cntN;
            flagsQ      <= flagsN;
            redirectQ   <= redirectN;
            redirectPcQ <= redirectPcN;
            takenCntQ   <= takenCntN;
        end
    end

    assign flags_out   = flagsQ;
    assign redirect    = redirectQ;
    assign redirect_pc = redirectPcQ;
    assign flush       = (stateQ == FBU_FLUSH);
    assign busy        = (stateQ == FBU_FLUSH);
    assign taken_cnt   = takenCntQ;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: condition sweep table plus hand-written multi-cycle sequences.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_flag_branch_unit;
    import flag_branch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flag_we;
    logic        v_in, z_in, n_in;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_pc_plus1;
    logic [8:0]  br_offset;
    logic [2:0]  flags_out;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush;
    logic        busy;
    logic [15:0] taken_cnt;

    always #5 clk = ~clk;

    flag_branch_unit #(.FLUSH_CYCLES(2), .PC_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flag_we     (flag_we),
        .v_in        (v_in),
        .z_in        (z_in),
        .n_in        (n_in),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .br_pc_plus1 (br_pc_plus1),
        .br_offset   (br_offset),
        .flags_out   (flags_out),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .busy        (busy),
        .taken_cnt   (taken_cnt)
    );

    typedef struct {
        logic [2:0]  flg;
        logic [2:0]  cond;
        logic [15:0] pc;
        logic [8:0]  off;
        logic        expTaken;
        logic [15:0] expPc;
    } vec_t;

    vec_t        vec[24];
    logic [2:0]  flgSet[3];
    logic [15:0] pcSet[3];
    logic [8:0]  offSet[3];
    logic [7:0]  maskSet[3];
    logic [15:0] expPcSet[3];

    int          passCnt  = 0;
    int          totalCnt = 0;
    logic [15:0] expCnt   = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        stall       = 1'b0;
        flag_we     = 1'b0;
        {v_in, z_in, n_in} = 3'b000;
        br_valid    = 1'b0;
        br_cond     = BR_NE;
        br_pc_plus1 = 16'h0000;
        br_offset   = 9'h000;
    endtask

    task automatic writeFlags(input logic [2:0] f);
        flag_we = 1'b1;
        {v_in, z_in, n_in} = f;
        tick();
        flag_we = 1'b0;
    endtask

    // Launch one branch in EX for a single edge; outputs of that edge are visible on return
    task automatic branch(input logic [2:0] c, input logic [15:0] pc, input logic [8:0] off);
        br_valid    = 1'b1;
        br_cond     = c;
        br_pc_plus1 = pc;
        br_offset   = off;
        tick();
        br_valid    = 1'b0;
    endtask

    initial begin
        // Sweep sets: flags, pc, offset, taken mask indexed by cond, expected target
        flgSet[0] = 3'b010; pcSet[0] = 16'h0100; offSet[0] = 9'h010; maskSet[0] = 8'b1011_0010; expPcSet[0] = 16'h0110;
        flgSet[1] = 3'b001; pcSet[1] = 16'h0200; offSet[1] = 9'h1F0; maskSet[1] = 8'b1010_1001; expPcSet[1] = 16'h01F0;
        flgSet[2] = 3'b100; pcSet[2] = 16'h7FF0; offSet[2] = 9'h0FF; maskSet[2] = 8'b1101_0101; expPcSet[2] = 16'h80EF;
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 8; c++) begin
                vec[s*8+c] = '{flgSet[s], 3'(c), pcSet[s], offSet[s], maskSet[s][c], expPcSet[s]};
            end
        end

        // ---- reset state ----
        idleInputs();
        rst_n = 1'b0;
        #12;
        check("rst_flags",    32'(flags_out),   32'h0);
        check("rst_redirect", 32'(redirect),    32'h0);
        check("rst_pc",       32'(redirect_pc), 32'h0);
        check("rst_flush",    32'(flush),       32'h0);
        check("rst_busy",     32'(busy),        32'h0);
        check("rst_cnt",      32'(taken_cnt),   32'h0);
        #1 rst_n = 1'b1;
        tick();

        // ---- flush window with wrong-path traffic, negative offset target ----
        branch(BR_UN, 16'h0010, 9'h1FE);
        expCnt = 16'd1;
        check("fw_redirect0", 32'(redirect),    32'h1);
        check("fw_pc",        32'(redirect_pc), 32'h000E);
        check("fw_flush0",    32'(flush),       32'h1);
        check("fw_busy0",     32'(busy),        32'h1);
        check("fw_cnt",       32'(taken_cnt),   32'h1);
        br_valid = 1'b1; br_cond = BR_UN; br_pc_plus1 = 16'h1234; br_offset = 9'h011;
        flag_we  = 1'b1; {v_in, z_in, n_in} = 3'b111;
        tick();
        check("fw_redirect1", 32'(redirect), 32'h0);
        check("fw_flush1",    32'(flush),    32'h1);
        check("fw_busy1",     32'(busy),     32'h1);
        tick();
        idleInputs();
        check("fw_flush2",    32'(flush),       32'h0);
        check("fw_busy2",     32'(busy),        32'h0);
        check("fw_redirect2", 32'(redirect),    32'h0);
        check("fw_flags",     32'(flags_out),   32'h0);
        check("fw_cnt_after", 32'(taken_cnt),   32'h1);
        check("fw_pc_hold",   32'(redirect_pc), 32'h000E);

        // ---- condition sweep table ----
        for (int i = 0; i < 24; i++) begin
            writeFlags(vec[i].flg);
            check("sw_flags", 32'(flags_out), 32'(vec[i].flg));
            branch(vec[i].cond, vec[i].pc, vec[i].off);
            check($sformatf("sw_redirect[%0d]", i), 32'(redirect), 32'(vec[i].expTaken));
            check($sformatf("sw_flush[%0d]", i),    32'(flush),    32'(vec[i].expTaken));
            if (vec[i].expTaken) begin
                expCnt = expCnt + 16'd1;
                check($sformatf("sw_pc[%0d]", i), 32'(redirect_pc), 32'(vec[i].expPc));
            end
            tick();
            tick();
            check($sformatf("sw_idle[%0d]", i), 32'(busy),      32'h0);
            check($sformatf("sw_cnt[%0d]", i),  32'(taken_cnt), 32'(expCnt));
        end

        // ---- same-cycle flag bypass ----
        writeFlags(3'b000);
        flag_we = 1'b1; {v_in, z_in, n_in} = 3'b010;
        branch(BR_EQ, 16'h0040, 9'h000);
        flag_we = 1'b0;
        expCnt = expCnt + 16'd1;
        check("byp_redirect", 32'(redirect),    32'h1);
        check("byp_pc",       32'(redirect_pc), 32'h0040);
        check("byp_flags",    32'(flags_out),   32'h2);
        tick(); tick();
        writeFlags(3'b000);
        {v_in, z_in, n_in} = 3'b010;
        branch(BR_EQ, 16'h0050, 9'h000);
        check("nobyp_redirect", 32'(redirect),  32'h0);
        check("nobyp_flags",    32'(flags_out), 32'h0);

        // ---- target wrap ----
        branch(BR_UN, 16'hFFFF, 9'h001);
        expCnt = expCnt + 16'd1;
        check("wrap_pc", 32'(redirect_pc), 32'h0000);
        tick(); tick();

        // ---- stall in IDLE: no branch evaluation, no flag write ----
        stall = 1'b1;
        flag_we = 1'b1; {v_in, z_in, n_in} = 3'b111;
        branch(BR_UN, 16'h0300, 9'h000);
        flag_we = 1'b0; stall = 1'b0;
        check("stl_idle_redirect", 32'(redirect),  32'h0);
        check("stl_idle_flags",    32'(flags_out), 32'h0);
        check("stl_idle_cnt",      32'(taken_cnt), 32'(expCnt));

        // ---- stall right after redirect: pulse stretches, flush lasts 5 cycles ----
        branch(BR_UN, 16'h0400, 9'h004);
        expCnt = expCnt + 16'd1;
        check("stl_redirect0", 32'(redirect), 32'h1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stl_redirect_hold%0d", k), 32'(redirect),  32'h1);
            check($sformatf("stl_flush_hold%0d", k),    32'(flush),     32'h1);
            check($sformatf("stl_cnt_hold%0d", k),      32'(taken_cnt), 32'(expCnt));
        end
        stall = 1'b0;
        tick();
        check("stl_redirect_drop", 32'(redirect), 32'h0);
        check("stl_flush4",        32'(flush),    32'h1);
        tick();
        check("stl_flush_end", 32'(flush),       32'h0);
        check("stl_pc",        32'(redirect_pc), 32'h0404);

        // ---- taken counter saturation ----
        force dut.takenCntQ = 16'hFFFE;
        #2;
        release dut.takenCntQ;
        check("sat_preload", 32'(taken_cnt), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            branch(BR_UN, 16'h0500, 9'h000);
            check($sformatf("sat_cnt%0d", k), 32'(taken_cnt), 32'hFFFF);
            tick(); tick();
        end
        check("sat_final", 32'(taken_cnt), 32'hFFFF);

        // ---- asynchronous reset in the middle of a flush ----
        branch(BR_UN, 16'h0600, 9'h002);
        check("mid_busy_before", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_redirect", 32'(redirect),    32'h0);
        check("mid_pc",       32'(redirect_pc), 32'h0);
        check("mid_flush",    32'(flush),       32'h0);
        check("mid_busy",     32'(busy),        32'h0);
        check("mid_cnt",      32'(taken_cnt),   32'h0);
        check("mid_flags",    32'(flags_out),   32'h0);
        #2 rst_n = 1'b1;
        tick();
        check("mid_idle_after", 32'(busy),     32'h0);
        check("mid_no_redirect", 32'(redirect), 32'h0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
